// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Contents: FSM state encoding, the counter saturation limit, and a saturating increment.
// Ports: none (package).
package mem_pkg;

    typedef enum logic {SWEEP, RUN} mem_state_t;

    localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

    // Holds at SAT_MAX instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == SAT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder: one synchronous write port, one async read port.
// Latency: write commits at posedge; read is combinational from raddr (shows pre-write word in the write cycle).
// Ports: CLK, we/waddr/wdata (write), raddr/rdata (read). No reset; the parent clears it by sweeping.
module dmem_array #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10
) (
    input  logic                 CLK,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory port; owns the storage, zero-sweeps it after reset, accepts preloads.
// Latency: loads combinational from daddr (same cycle); stores and preloads commit at the next posedge.
// Backpressure: ld_ready drops while the core stores or while the sweep runs; core accesses in SWEEP are ignored.
// Ports: CLK/RESET; core side daddr, ddata_w, mem_write, mem_read, ddata_r; preload side ld_valid, ld_ready,
//        ld_addr, ld_data; status READY, rd_count, wr_count (saturating).
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [ADDR_SIZE-1:0] daddr,
    input  logic [DATA_SIZE-1:0] ddata_w,
    input  logic                 mem_write,
    input  logic                 mem_read,
    output logic [DATA_SIZE-1:0] ddata_r,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [ADDR_SIZE-1:0] ld_addr,
    input  logic [DATA_SIZE-1:0] ld_data,
    output logic                 READY,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
);

    localparam int DEPTH = 2 ** ADDR_SIZE;
    // One extra bit so the pointer can step past the last word without aliasing word 0.
    localparam logic [ADDR_SIZE:0] LAST_PTR = (ADDR_SIZE + 1)'(DEPTH - 1);
    localparam logic [ADDR_SIZE:0] PTR_ONE  = (ADDR_SIZE + 1)'(1);

    mem_state_t           state, state_nxt;
    logic [ADDR_SIZE:0]   sweep_ptr, sweep_ptr_nxt;

    logic                 arr_we;
    logic [ADDR_SIZE-1:0] arr_waddr;
    logic [DATA_SIZE-1:0] arr_wdata;
    logic [DATA_SIZE-1:0] arr_rdata;

    logic [31:0]          rd_cnt_q;
    logic [31:0]          wr_cnt_q;

    // ---------------- FSM ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= SWEEP;
            sweep_ptr <= '0;
        end else begin
            state     <= state_nxt;
            sweep_ptr <= sweep_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sweep_ptr_nxt = sweep_ptr;
        case (state)
            SWEEP: begin
                sweep_ptr_nxt = sweep_ptr + PTR_ONE;
                if (sweep_ptr == LAST_PTR) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = SWEEP;
            end
        endcase
    end

    assign READY    = (state == RUN);
    // A core store owns the single write port, so the preload waits behind it.
    assign ld_ready = READY && !mem_write;

    // ---------------- write-port arbitration ----------------
    // Priority: sweep, then core store, then preload. Nothing is written in a reset cycle.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = '0;
        arr_wdata = '0;
        if (!RESET) begin
            if (state == SWEEP) begin
                arr_we    = 1'b1;
                arr_waddr = sweep_ptr[ADDR_SIZE-1:0];
                arr_wdata = '0;
            end else if (mem_write) begin
                arr_we    = 1'b1;
                arr_waddr = daddr;
                arr_wdata = ddata_w;
            end else if (ld_valid) begin
                arr_we    = 1'b1;
                arr_waddr = ld_addr;
                arr_wdata = ld_data;
            end
        end
    end

    dmem_array #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .CLK   (CLK),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (daddr),
        .rdata (arr_rdata)
    );

    // Async read gives read-before-write for a same-cycle store to the same word.
    assign ddata_r = READY ? arr_rdata : '0;

    // ---------------- counters ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (READY && mem_read) begin
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
            if (READY && mem_write) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 2 ** AW;
    localparam logic [31:0] MAXV = 32'hFFFF_FFFF;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [AW-1:0] daddr;
    logic [DW-1:0] ddata_w;
    logic          mem_write;
    logic          mem_read;
    logic [DW-1:0] ddata_r;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          READY;
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;

    int total = 0;
    int bad   = 0;

    // Reference model: storage image, readiness and counters as the behaviour describes them.
    bit          m_valid = 1'b0;
    bit          m_ready = 1'b0;
    int          m_left  = 0;
    logic [31:0] mm [DEPTH];
    logic [31:0] m_rd;
    logic [31:0] m_wr;

    always #5 CLK = ~CLK;

    data_mem_responder #(
        .DATA_SIZE (DW),
        .ADDR_SIZE (AW)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .daddr     (daddr),
        .ddata_w   (ddata_w),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .ddata_r   (ddata_r),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .READY     (READY),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        if (m_valid) begin
            chk({tag, ".ready"},    {31'd0, READY},    {31'd0, m_ready});
            chk({tag, ".ld_ready"}, {31'd0, ld_ready}, {31'd0, (m_ready && !mem_write)});
            chk({tag, ".ddata_r"},  ddata_r,           m_ready ? mm[daddr] : 32'd0);
            chk({tag, ".rd_count"}, rd_count,          m_rd);
            chk({tag, ".wr_count"}, wr_count,          m_wr);
        end
    endtask

    // Advance the model by one clock using the inputs that the DUT samples at this edge.
    task automatic model_step();
        if (RESET) begin
            m_valid = 1'b1;
            m_ready = 1'b0;
            m_left  = DEPTH;
            m_rd    = 32'd0;
            m_wr    = 32'd0;
        end else if (m_valid) begin
            if (!m_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < DEPTH; i++) mm[i] = 32'd0;
                end
            end else begin
                if (mem_read && m_rd != MAXV) m_rd++;
                if (mem_write) begin
                    mm[daddr] = ddata_w;
                    if (m_wr != MAXV) m_wr++;
                end else if (ld_valid) begin
                    mm[ld_addr] = ld_data;
                end
            end
        end
    endtask

    // Entered just after a posedge with new inputs applied; checks, clocks, returns just after the next posedge.
    task automatic cyc(input string tag);
        #1;
        check_outputs(tag);
        model_step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; daddr = '0; ddata_w = '0; mem_write = 1'b0; mem_read = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        @(posedge CLK);
        #1;

        // 1: single reset cycle, then idle through the sweep
        cyc("reset");
        RESET = 1'b0;
        repeat (DEPTH) cyc("sweep");
        #1;
        chk("ready_after_sweep", {31'd0, READY}, 32'd1);
        chk("rd_count_zero", rd_count, 32'd0);
        chk("wr_count_zero", wr_count, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            daddr = AW'(i);
            #0.1;
            chk("swept_zero", ddata_r, 32'd0);
        end
        @(posedge CLK);
        #1;

        // 2: preload accepted in one cycle
        ld_valid = 1'b1; ld_addr = AW'(5); ld_data = 32'hDEAD_BEEF;
        #1;
        chk("preload_ready", {31'd0, ld_ready}, 32'd1);
        cyc("preload");
        ld_valid = 1'b0; daddr = AW'(5);
        #1;
        chk("preload_read", ddata_r, 32'hDEAD_BEEF);
        chk("preload_no_wr", wr_count, 32'd0);
        cyc("preload_chk");

        // 3: store and load to the same word in one cycle
        daddr = AW'(7); ddata_w = 32'h1234_5678; mem_write = 1'b1; mem_read = 1'b1;
        #1;
        chk("rbw_old", ddata_r, 32'd0);
        cyc("rbw");
        mem_write = 1'b0; mem_read = 1'b0;
        #1;
        chk("rbw_new", ddata_r, 32'h1234_5678);
        chk("rbw_rd", rd_count, 32'd1);
        chk("rbw_wr", wr_count, 32'd1);
        cyc("rbw_chk");

        // 4: preload held off by core stores, then commits last
        daddr = AW'(9); ddata_w = 32'hAAAA_0009; mem_write = 1'b1;
        ld_valid = 1'b1; ld_addr = AW'(9); ld_data = 32'h5555_0009;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("prio_ld_ready_low", {31'd0, ld_ready}, 32'd0);
            cyc("prio");
        end
        mem_write = 1'b0;
        #1;
        chk("prio_ld_ready_high", {31'd0, ld_ready}, 32'd1);
        cyc("prio_xfer");
        ld_valid = 1'b0;
        #1;
        chk("prio_final", ddata_r, 32'h5555_0009);
        cyc("prio_chk");

        // Randomised traffic over a small address window to force collisions
        for (int n = 0; n < 400; n++) begin
            // Preload address/data stay put while a request is pending and not accepted.
            if (!(ld_valid && mem_write)) begin
                ld_valid = ($urandom_range(0, 2) == 0);
                ld_addr  = AW'($urandom_range(0, 15));
                ld_data  = $urandom;
            end else if ($urandom_range(0, 5) == 0) begin
                ld_valid = 1'b0;
            end
            daddr     = AW'($urandom_range(0, 15));
            ddata_w   = $urandom;
            mem_write = ($urandom_range(0, 2) == 0);
            mem_read  = ($urandom_range(0, 1) == 0);
            cyc("rand");
        end
        mem_write = 1'b0; mem_read = 1'b0; ld_valid = 1'b0;

        // 5: reset mid-sweep after a preload; word 3 must come back zero
        ld_valid = 1'b1; ld_addr = AW'(3); ld_data = 32'h3333_3333;
        cyc("pre3");
        ld_valid = 1'b0; daddr = AW'(3);
        #1;
        chk("pre3_read", ddata_r, 32'h3333_3333);
        RESET = 1'b1;
        cyc("rst2");
        RESET = 1'b0;
        repeat (DEPTH / 2) cyc("half_sweep");
        RESET = 1'b1;
        cyc("rst3");
        RESET = 1'b0;
        repeat (DEPTH - 1) cyc("resweep");
        #1;
        chk("resweep_not_ready", {31'd0, READY}, 32'd0);
        cyc("resweep_last");
        #1;
        chk("resweep_ready", {31'd0, READY}, 32'd1);
        chk("resweep_word3", ddata_r, 32'd0);
        cyc("resweep_chk");

        // 6: read counter saturation
        force dut.rd_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.rd_cnt_q;
        m_rd = 32'hFFFF_FFFE;
        #1;
        chk("sat_start", rd_count, 32'hFFFF_FFFE);
        mem_read = 1'b1;
        daddr = AW'(1);
        for (int k = 0; k < 3; k++) begin
            cyc("sat");
            #1;
            chk("sat_value", rd_count, 32'hFFFF_FFFF);
        end
        mem_read = 1'b0;
        cyc("sat_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound on runtime so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
